fp_normalize: RTL and testbench

Pipelined post-arithmetic normalizer for the FPU datapath. It left-shifts an unnormalized mantissa by its leading-zero count and decrements the exponent to match. When the exponent would drop below the minimum normal, the shift is clamped and the result is flagged subnormal. It sits between the adder/multiplier/int-to-float result stage and the rounding unit, with valid/ready handshakes on both sides.

---
 rtl/fp_normalize_pkg.sv | 19 +
 rtl/lzc.sv | 21 ++
 rtl/fp_normalize.sv | 129 ++++++++++++
 tb/tb_fp_normalize.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_pkg.sv
// Shared FPU types and constants used by the normalizer.
package fp_normalize_pkg;

  // Smallest biased exponent that a normal result can carry
  localparam int EXP_MIN_NORMAL = 1;

  // Default FPU exponent width, including headroom bits
  localparam int FPU_EXP_WIDTH  = 10;

  // Side-band flags that travel with a normalized beat
  typedef struct packed {
    logic zero;
    logic denorm;
  } norm_flags_t;

  // Signed biased exponent at the default FPU width
  typedef logic signed [FPU_EXP_WIDTH-1:0] fpu_exp_t;

endpackage

// File: rtl/lzc.sv
// Leading-zero counter. An all-zero input reports zero_o with cnt_o = 0.
module lzc #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     zero_o
);

  localparam int CW = $clog2(WIDTH);

  // Scan from the LSB upwards, so the highest set bit determines the count
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++)
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/fp_normalize.sv
// Two-stage mantissa normalizer: stage A decides shift/exponent/flags,
// stage B applies the barrel shift. Valid/ready on both sides.
module fp_normalize
  import fp_normalize_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int EXP_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     man_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     man_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic                 zero_o,
  output logic                 denorm_o
);

  localparam int STAGES = 2;
  localparam int SW     = $clog2(WIDTH);
  localparam int XW     = EXP_WIDTH + 1;   // one extra bit so e - cnt never wraps

  typedef logic signed [XW-1:0] exp_x_t;

  logic [STAGES:1] vld_pipe;   // [1] = stage A, [2] = stage B
  logic            ld_a, ld_b;

  logic [SW-1:0]   lz_cnt;
  logic            lz_zero;

  exp_x_t          e_x, cnt_x, diff, emin, clamp_sh;
  logic [SW-1:0]   sh_d;
  logic [EXP_WIDTH-1:0] exp_d;
  norm_flags_t     flg_d;

  logic [WIDTH-1:0]     man_a, man_b, sh_man;
  logic [SW-1:0]        sh_a;
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  norm_flags_t          flg_a, flg_b;

  // Stage B frees up when empty or drained; stage A follows stage B
  assign ld_b    = ~vld_pipe[2] | ready_i;
  assign ld_a    = ~vld_pipe[1] | ld_b;
  assign ready_o = ~vld_pipe[1] | ~vld_pipe[2] | ready_i;

  lzc #(.WIDTH(WIDTH)) u_lzc (
    .in_i   (man_i),
    .cnt_o  (lz_cnt),
    .zero_o (lz_zero)
  );

  assign e_x      = exp_x_t'($signed(exp_i));
  assign cnt_x    = exp_x_t'(lz_cnt);
  assign emin     = exp_x_t'(EXP_MIN_NORMAL);
  assign diff     = e_x - cnt_x;
  assign clamp_sh = e_x - emin;   // < cnt in the clamp case, so it fits in SW bits

  // Classify the beat: zero, underrange, full normalize or clamped shift
  always_comb begin
    sh_d  = '0;
    exp_d = '0;
    flg_d = '0;
    if (lz_zero) begin
      flg_d.zero = 1'b1;
    end else if (e_x < emin) begin
      flg_d.denorm = 1'b1;
    end else if (diff >= emin) begin
      sh_d  = lz_cnt;
      exp_d = EXP_WIDTH'(diff);
    end else begin
      sh_d         = SW'(clamp_sh);
      flg_d.denorm = 1'b1;
    end
  end

  // Stage A registers; data only moves when a real beat is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[1] <= 1'b0;
      man_a       <= '0;
      sh_a        <= '0;
      exp_a       <= '0;
      flg_a       <= '0;
    end else if (ld_a) begin
      vld_pipe[1] <= valid_i;
      if (valid_i) begin
        man_a <= lz_zero ? '0 : man_i;
        sh_a  <= sh_d;
        exp_a <= exp_d;
        flg_a <= flg_d;
      end
    end
  end

  // Log-depth barrel shift; shifted-out bits are known zero
  always_comb begin
    sh_man = man_a;
    for (int l = 0; l < SW; l++)
      if (sh_a[l]) sh_man = sh_man << (1 << l);
  end

  // Stage B registers; outputs hold while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[2] <= 1'b0;
      man_b       <= '0;
      exp_b       <= '0;
      flg_b       <= '0;
    end else if (ld_b) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        man_b <= sh_man;
        exp_b <= exp_a;
        flg_b <= flg_a;
      end
    end
  end

  assign valid_o  = vld_pipe[2];
  assign man_o    = man_b;
  assign exp_o    = exp_b;
  assign zero_o   = flg_b.zero;
  assign denorm_o = flg_b.denorm;

endmodule

// File: tb/tb_fp_normalize.sv
// Randomized + directed bench for fp_normalize with a queue scoreboard.
module tb_fp_normalize;

  localparam int W  = 28;
  localparam int EW = 10;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_i, ready_o, valid_o, ready_i;
  logic [W-1:0]  man_i, man_o;
  logic [EW-1:0] exp_i, exp_o;
  logic          zero_o, denorm_o;

  typedef struct {
    logic [W-1:0] m;
    int           e;
    logic         z;
    logic         d;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fp_normalize #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .man_i    (man_i),
    .exp_i    (exp_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .man_o    (man_o),
    .exp_o    (exp_o),
    .zero_o   (zero_o),
    .denorm_o (denorm_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: count leading zeros, then apply the exponent floor of 1
  function automatic res_t model(input logic [W-1:0] m, input int e);
    res_t r;
    int   lz;
    r.m = m; r.e = 0; r.z = 1'b0; r.d = 1'b0;
    if (m == 0) begin
      r.z = 1'b1;
      return r;
    end
    lz = 0;
    while (m[W-1-lz] == 1'b0) lz++;
    if (e < 1) begin
      r.d = 1'b1;
    end else if (e - lz >= 1) begin
      r.m = m << lz;
      r.e = e - lz;
    end else begin
      r.m = m << (e - 1);
      r.d = 1'b1;
    end
    return r;
  endfunction

  // One clock: drive at negedge, sample #1 later, score what the next edge does
  task automatic cycle(input logic v, input logic [W-1:0] m, input int e, input logic r);
    res_t x;
    @(negedge clk);
    valid_i = v; man_i = m; exp_i = EW'(e); ready_i = r;
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        x = sb[0];
        chk("man", 64'(man_o), 64'(x.m));
        chk("exp", 64'(exp_o), 64'(EW'(x.e)));
        chk("zero", 64'(zero_o), 64'(x.z));
        chk("denorm", 64'(denorm_o), 64'(x.d));
        if (ready_i) void'(sb.pop_front());
      end
    end
    if (v && ready_o) sb.push_back(model(m, e));
  endtask

  // Single beat into an empty pipe, with explicit expected values and latency
  task automatic directed(input string tag, input logic [W-1:0] m, input int e,
                          input logic [W-1:0] xm, input int xe, input logic xz, input logic xd);
    cycle(1'b1, m, e, 1'b1);
    chk({tag, "_accept"}, 64'(ready_o), 64'd1);
    cycle(1'b0, '0, 0, 1'b1);
    chk({tag, "_lat_early"}, 64'(valid_o), 64'd0);
    cycle(1'b0, '0, 0, 1'b1);
    chk({tag, "_lat_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_man"}, 64'(man_o), 64'(xm));
    chk({tag, "_exp"}, 64'(exp_o), 64'(EW'(xe)));
    chk({tag, "_zero"}, 64'(zero_o), 64'(xz));
    chk({tag, "_denorm"}, 64'(denorm_o), 64'(xd));
  endtask

  function automatic logic [W-1:0] rand_man();
    logic [W-1:0] m;
    if ($urandom_range(0, 9) == 0) return '0;
    m = W'($urandom);
    return m >> $urandom_range(0, W - 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] bman [5];
    logic [W-1:0] pm;
    int           pe, idx;
    logic         pv, rr, vv;

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; man_i = '0; exp_i = '0;
    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_man", 64'(man_o), 64'd0);
    chk("rst_exp", 64'(exp_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    directed("normal",   28'h0400000, 100, 28'h8000000, 95, 1'b0, 1'b0);
    directed("edge_e6",  28'h0400000,   6, 28'h8000000,  1, 1'b0, 1'b0);
    directed("edge_e5",  28'h0400000,   5, 28'h4000000,  0, 1'b0, 1'b1);
    directed("clamp",    28'h0000100,   5, 28'h0001000,  0, 1'b0, 1'b1);
    directed("underrng", 28'h0000100,  -3, 28'h0000100,  0, 1'b0, 1'b1);
    directed("zero",     28'h0000000,  50, 28'h0000000,  0, 1'b1, 1'b0);
    directed("top_bit",  28'h8000001,   1, 28'h8000001,  1, 1'b0, 1'b0);

    // Backpressure: five beats, downstream stalls in cycles 3..5
    bman[0] = 28'h0000001; bman[1] = 28'h0001234; bman[2] = 28'h4000000;
    bman[3] = 28'h0000000; bman[4] = 28'h00F0F00;
    idx = 0;
    for (int c = 1; c <= 12; c++) begin
      rr = !(c >= 3 && c <= 5);
      vv = (idx < 5);
      cycle(vv, vv ? bman[idx] : '0, 40, rr);
      if (c == 3) chk("bp_ready_low", 64'(ready_o), 64'd0);
      if (c >= 3 && c <= 5) chk("bp_hold_valid", 64'(valid_o), 64'd1);
      if (c >= 6 && c <= 10) chk("bp_no_bubble", 64'(valid_o), 64'd1);
      if (vv && ready_o) idx++;
    end
    chk("bp_all_taken", 64'(idx), 64'd5);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Random traffic with random backpressure; upstream holds until taken
    pv = 1'b0; pm = '0; pe = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pm = rand_man();
        pe = int'($urandom_range(0, 80)) - 20;
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(pv, pm, pe, rr);
      if (pv && ready_o) pv = 1'b0;
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, '0, 0, 1'b1);
    chk("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full and downstream stalled
    cycle(1'b1, 28'h0000F00, 20, 1'b1);
    cycle(1'b1, 28'h0030000, 20, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_man", 64'(man_o), 64'd0);
    chk("mid_rst_flags", 64'({zero_o, denorm_o}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    directed("post_rst", 28'h0000010, 30, 28'h8000000, 7, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("post_rst_no_stale", 64'(valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
